// File: rtl/clk_div_multi_if.sv
// -----------------------------------------------------------------------------
// clk_div_multi_if
// Bundles the per-channel control and status vectors of clk_div_multi.
//   EN      : per-channel run enable                      (master -> slave)
//   DIV_VAL : requested divisors, channel i at [i*CNT_W +: CNT_W]
//   LOAD    : per-channel strobe capturing DIV_VAL into the shadow divisor
//   CLK_out : registered divided clock per channel        (slave -> master)
//   TICK    : registered one-cycle period-start pulse per channel
//   PEND    : a shadow divisor is waiting to be applied
// The divider itself is the slave; the block that programs it is the master.
// -----------------------------------------------------------------------------
interface clk_div_multi_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 16
);
    logic [NUM_CH-1:0]       EN;
    logic [NUM_CH*CNT_W-1:0] DIV_VAL;
    logic [NUM_CH-1:0]       LOAD;
    logic [NUM_CH-1:0]       CLK_out;
    logic [NUM_CH-1:0]       TICK;
    logic [NUM_CH-1:0]       PEND;

    modport master (
        output EN,
        output DIV_VAL,
        output LOAD,
        input  CLK_out,
        input  TICK,
        input  PEND
    );

    modport slave (
        input  EN,
        input  DIV_VAL,
        input  LOAD,
        output CLK_out,
        output TICK,
        output PEND
    );
endinterface

// File: rtl/clk_div_multi.sv
// -----------------------------------------------------------------------------
// clk_div_multi
// Multi-channel synchronous programmable clock divider. Each channel runs a
// phase counter clocked by CLK and produces a near-50% divided waveform
// (CLK_out, high for ceil(D/2) cycles) plus a one-cycle TICK at the start of
// every period. Divisors are changed through a shadow register and only take
// effect at a period boundary, so CLK_out never produces a runt pulse.
//
// Ports:
//   CLK  : sole clock, rising edge
//   RST  : asynchronous active-high reset
//   SYNC : (only with CLKDIV_SYNC_EN) restarts all channels together
//   bus  : clk_div_multi_if.slave (EN, DIV_VAL, LOAD in; CLK_out, TICK, PEND out)
//
// Optional feature macro: CLKDIV_SYNC_EN adds the SYNC input.
// -----------------------------------------------------------------------------
module clk_div_multi #(
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = 16,
    parameter int DIV_RST = 2
) (
    input  logic             CLK,
    input  logic             RST,
`ifdef CLKDIV_SYNC_EN
    input  logic             SYNC,
`endif
    clk_div_multi_if.slave   bus
);

    localparam logic [CNT_W-1:0] ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] DIV_INI = CNT_W'(DIV_RST);

    logic [NUM_CH-1:0] clk_out_vec;
    logic [NUM_CH-1:0] tick_vec;
    logic [NUM_CH-1:0] pend_vec;

    logic sync_w;
`ifdef CLKDIV_SYNC_EN
    assign sync_w = SYNC;
`else
    assign sync_w = 1'b0;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [CNT_W-1:0] p_q, p_d;
            logic [CNT_W-1:0] div_q, div_d;
            logic [CNT_W-1:0] shadow_q, shadow_d;
            logic             pend_q, pend_d;
            logic             clk_q, clk_d;
            logic             tick_q, tick_d;

            logic [CNT_W-1:0] div_in;
            logic [CNT_W-1:0] half;
            logic             en_in;
            logic             load_in;
            logic             wrap;

            assign div_in  = bus.DIV_VAL[gi*CNT_W +: CNT_W];
            assign en_in   = bus.EN[gi];
            assign load_in = bus.LOAD[gi];
            // ceil(D/2): number of high cycles in each period
            assign half    = div_q - (div_q >> 1);

            always_comb begin
                p_d      = p_q;
                div_d    = div_q;
                shadow_d = shadow_q;
                pend_d   = pend_q;
                clk_d    = clk_q;
                tick_d   = 1'b0;
                wrap     = 1'b0;

                if (sync_w) begin
                    // Park at all-ones so the next enabled edge is a period
                    // start in every channel; LOAD is ignored on this edge.
                    p_d   = '1;
                    clk_d = 1'b0;
                    if (pend_q) begin
                        div_d  = shadow_q;
                        pend_d = 1'b0;
                    end
                end else begin
                    if (en_in) begin
                        if (div_q == '0) begin
                            // Parked channel: outputs low, still a load point.
                            wrap  = 1'b1;
                            p_d   = '1;
                            clk_d = 1'b0;
                        end else begin
                            // >= (not ==) so a shrunken divisor forces a wrap.
                            wrap   = (p_q >= div_q - ONE);
                            p_d    = wrap ? '0 : p_q + ONE;
                            tick_d = wrap;
                            clk_d  = (p_d < half);
                        end
                    end
                    // Only a load already pending before this edge is applied;
                    // the wrap decision above used the old divisor.
                    if (wrap && pend_q) begin
                        div_d  = shadow_q;
                        pend_d = 1'b0;
                    end
                    // A fresh LOAD always wins the pending flag and the shadow.
                    if (load_in) begin
                        shadow_d = div_in;
                        pend_d   = 1'b1;
                    end
                end
            end

            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    p_q      <= '1;
                    div_q    <= DIV_INI;
                    shadow_q <= DIV_INI;
                    pend_q   <= 1'b0;
                    clk_q    <= 1'b0;
                    tick_q   <= 1'b0;
                end else begin
                    p_q      <= p_d;
                    div_q    <= div_d;
                    shadow_q <= shadow_d;
                    pend_q   <= pend_d;
                    clk_q    <= clk_d;
                    tick_q   <= tick_d;
                end
            end

            assign clk_out_vec[gi] = clk_q;
            assign tick_vec[gi]    = tick_q;
            assign pend_vec[gi]    = pend_q;
        end
    endgenerate

    assign bus.CLK_out = clk_out_vec;
    assign bus.TICK    = tick_vec;
    assign bus.PEND    = pend_vec;

endmodule

// File: tb/tb_clk_div_multi.sv
// -----------------------------------------------------------------------------
// tb_clk_div_multi
// Directed, table-driven bench for clk_div_multi (NUM_CH=4, CNT_W=16,
// DIV_RST=2). Inputs change and outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_clk_div_multi;

    localparam int NCH = 4;
    localparam int CW  = 16;

    logic CLK;
    logic RST;
`ifdef CLKDIV_SYNC_EN
    logic SYNC;
`endif

    int total;
    int bad;

    clk_div_multi_if #(.NUM_CH(NCH), .CNT_W(CW)) bus ();

`ifdef CLKDIV_SYNC_EN
    clk_div_multi #(.NUM_CH(NCH), .CNT_W(CW), .DIV_RST(2)) dut (
        .CLK  (CLK),
        .RST  (RST),
        .SYNC (SYNC),
        .bus  (bus)
    );
`else
    clk_div_multi #(.NUM_CH(NCH), .CNT_W(CW), .DIV_RST(2)) dut (
        .CLK  (CLK),
        .RST  (RST),
        .bus  (bus)
    );
`endif

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [3:0]  en;
        logic [3:0]  load;
        logic [63:0] div;
        logic [3:0]  clk;
        logic [3:0]  tick;
        logic [3:0]  pend;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_ch(input string name, input int ch, input logic c, input logic t, input logic p);
        chk({name, "_clk"},  32'(bus.CLK_out[ch]), 32'(c));
        chk({name, "_tick"}, 32'(bus.TICK[ch]),    32'(t));
        chk({name, "_pend"}, 32'(bus.PEND[ch]),    32'(p));
        $display("%s ch%0d clk=%b tick=%b pend=%b", name, ch, bus.CLK_out[ch], bus.TICK[ch], bus.PEND[ch]);
    endtask

    task automatic step();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic set_div(input int ch, input logic [15:0] d);
        bus.DIV_VAL[ch*CW +: CW] = d;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        bus.EN = '0;
        bus.LOAD = '0;
        bus.DIV_VAL = '0;
`ifdef CLKDIV_SYNC_EN
        SYNC = 1'b0;
`endif
        #1;
        chk("rst_clk",  32'(bus.CLK_out), 32'h0);
        chk("rst_tick", 32'(bus.TICK),    32'h0);
        chk("rst_pend", 32'(bus.PEND),    32'h0);
        @(negedge CLK);
        RST = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;

        // {en, load, div{ch3,ch2,ch1,ch0}, exp clk, exp tick, exp pend}
        tbl[0] = '{4'b0000, 4'b0111, {16'd0, 16'd1, 16'd4, 16'd3}, 4'b0000, 4'b0000, 4'b0111};
        tbl[1] = '{4'b0111, 4'b0000, 64'd0, 4'b0111, 4'b0111, 4'b0000};
        tbl[2] = '{4'b0111, 4'b0000, 64'd0, 4'b0111, 4'b0100, 4'b0000};
        tbl[3] = '{4'b0111, 4'b0000, 64'd0, 4'b0100, 4'b0100, 4'b0000};
        tbl[4] = '{4'b0111, 4'b0000, 64'd0, 4'b0101, 4'b0101, 4'b0000};
        tbl[5] = '{4'b0111, 4'b0000, 64'd0, 4'b0111, 4'b0110, 4'b0000};
        tbl[6] = '{4'b0111, 4'b0000, 64'd0, 4'b0110, 4'b0100, 4'b0000};
        tbl[7] = '{4'b0111, 4'b0000, 64'd0, 4'b0101, 4'b0101, 4'b0000};
        tbl[8] = '{4'b0111, 4'b0000, 64'd0, 4'b0101, 4'b0100, 4'b0000};
        tbl[9] = '{4'b0111, 4'b0000, 64'd0, 4'b0110, 4'b0110, 4'b0000};

        // Table: ch0 D=3, ch1 D=4, ch2 D=1, ch3 idle
        do_reset();
        for (int i = 0; i < 10; i++) begin
            bus.EN      = tbl[i].en;
            bus.LOAD    = tbl[i].load;
            bus.DIV_VAL = tbl[i].div;
            step();
            chk($sformatf("vec%0d_clk", i),  32'(bus.CLK_out), 32'(tbl[i].clk));
            chk($sformatf("vec%0d_tick", i), 32'(bus.TICK),    32'(tbl[i].tick));
            chk($sformatf("vec%0d_pend", i), 32'(bus.PEND),    32'(tbl[i].pend));
            $display("vec %0d en=%b load=%b clk=%b tick=%b pend=%b",
                     i, tbl[i].en, tbl[i].load, bus.CLK_out, bus.TICK, bus.PEND);
        end

        // D=5 with two LOADs mid-period (2 then 3): only 3 ever takes effect
        do_reset();
        bus.LOAD = 4'b0001; set_div(0, 16'd5);
        step();                       expect_ch("b_ld5", 0, 1'b0, 1'b0, 1'b1);
        bus.LOAD = '0; bus.EN = 4'b0001;
        step();                       expect_ch("b_p0", 0, 1'b1, 1'b1, 1'b0);
        step();                       expect_ch("b_p1", 0, 1'b1, 1'b0, 1'b0);
        bus.LOAD = 4'b0001; set_div(0, 16'd2);
        step();                       expect_ch("b_p2", 0, 1'b1, 1'b0, 1'b1);
        set_div(0, 16'd3);
        step();                       expect_ch("b_p3", 0, 1'b0, 1'b0, 1'b1);
        bus.LOAD = '0;
        step();                       expect_ch("b_p4", 0, 1'b0, 1'b0, 1'b1);
        step();                       expect_ch("b_wrap", 0, 1'b1, 1'b1, 1'b0);
        step();                       expect_ch("b_n1", 0, 1'b1, 1'b0, 1'b0);
        step();                       expect_ch("b_n2", 0, 1'b0, 1'b0, 1'b0);
        step();                       expect_ch("b_n0", 0, 1'b1, 1'b1, 1'b0);

        // LOAD coincident with a wrap edge (4 -> 6)
        do_reset();
        bus.LOAD = 4'b0001; set_div(0, 16'd4);
        step();
        bus.LOAD = '0; bus.EN = 4'b0001;
        step();                       expect_ch("c_p0", 0, 1'b1, 1'b1, 1'b0);
        step(); step(); step();       expect_ch("c_p3", 0, 1'b0, 1'b0, 1'b0);
        bus.LOAD = 4'b0001; set_div(0, 16'd6);
        step();                       expect_ch("c_wrapld", 0, 1'b1, 1'b1, 1'b1);
        bus.LOAD = '0;
        step();                       expect_ch("c_q1", 0, 1'b1, 1'b0, 1'b1);
        step();                       expect_ch("c_q2", 0, 1'b0, 1'b0, 1'b1);
        step();                       expect_ch("c_q3", 0, 1'b0, 1'b0, 1'b1);
        step();                       expect_ch("c_wrap2", 0, 1'b1, 1'b1, 1'b0);
        step();                       expect_ch("c_s1", 0, 1'b1, 1'b0, 1'b0);
        step();                       expect_ch("c_s2", 0, 1'b1, 1'b0, 1'b0);
        step();                       expect_ch("c_s3", 0, 1'b0, 1'b0, 1'b0);
        step(); step();               expect_ch("c_s5", 0, 1'b0, 1'b0, 1'b0);
        step();                       expect_ch("c_s0", 0, 1'b1, 1'b1, 1'b0);

        // D=0 via LOAD with an EN pause mid-period
        do_reset();
        bus.LOAD = 4'b0001; set_div(0, 16'd3);
        step();
        bus.LOAD = '0; bus.EN = 4'b0001;
        step();                       expect_ch("d_p0", 0, 1'b1, 1'b1, 1'b0);
        step(); step();               expect_ch("d_p2", 0, 1'b0, 1'b0, 1'b0);
        bus.LOAD = 4'b0001; set_div(0, 16'd0);
        step();                       expect_ch("d_wrapld", 0, 1'b1, 1'b1, 1'b1);
        bus.LOAD = '0; bus.EN = '0;
        for (int k = 0; k < 3; k++) begin
            step();                   expect_ch($sformatf("d_hold%0d", k), 0, 1'b1, 1'b0, 1'b1);
        end
        bus.EN = 4'b0001;
        step();                       expect_ch("d_p1", 0, 1'b1, 1'b0, 1'b1);
        step();                       expect_ch("d_p2b", 0, 1'b0, 1'b0, 1'b1);
        step();                       expect_ch("d_wrap", 0, 1'b1, 1'b1, 1'b0);
        step();                       expect_ch("d_park1", 0, 1'b0, 1'b0, 1'b0);
        step();                       expect_ch("d_park2", 0, 1'b0, 1'b0, 1'b0);

        // Async reset at p=2 of a D=6 period, with a pending load discarded
        do_reset();
        bus.LOAD = 4'b0001; set_div(0, 16'd6);
        step();
        bus.LOAD = '0; bus.EN = 4'b0001;
        step();                       expect_ch("e_p0", 0, 1'b1, 1'b1, 1'b0);
        step();
        bus.LOAD = 4'b0001; set_div(0, 16'd9);
        step();                       expect_ch("e_p2", 0, 1'b1, 1'b0, 1'b1);
        bus.LOAD = '0;
        #2;
        RST = 1'b1;
        #1;
        expect_ch("e_rst", 0, 1'b0, 1'b0, 1'b0);
        @(negedge CLK);
        RST = 1'b0;
        step();                       expect_ch("e_first", 0, 1'b1, 1'b1, 1'b0);
        step();                       expect_ch("e_d2a", 0, 1'b0, 1'b0, 1'b0);
        step();                       expect_ch("e_d2b", 0, 1'b1, 1'b1, 1'b0);

`ifdef CLKDIV_SYNC_EN
        // SYNC realigns ch0 (D=3) and ch1 (D=6)
        do_reset();
        bus.LOAD = 4'b0011; set_div(0, 16'd3); set_div(1, 16'd6);
        step();
        bus.LOAD = '0; bus.EN = 4'b0001;
        step();
        bus.EN = 4'b0011;
        step(); step();
        SYNC = 1'b1;
        step();                       expect_ch("f_sync0", 0, 1'b0, 1'b0, 1'b0);
                                      expect_ch("f_sync1", 1, 1'b0, 1'b0, 1'b0);
        SYNC = 1'b0;
        step();                       expect_ch("f_start0", 0, 1'b1, 1'b1, 1'b0);
                                      expect_ch("f_start1", 1, 1'b1, 1'b1, 1'b0);
        for (int k = 1; k < 12; k++) begin
            step();
            chk($sformatf("f_t0_%0d", k), 32'(bus.TICK[0]), 32'((k % 3) == 0));
            chk($sformatf("f_t1_%0d", k), 32'(bus.TICK[1]), 32'((k % 6) == 0));
            $display("sync k=%0d tick=%b", k, bus.TICK[1:0]);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
